// File: rtl/prog_clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
// PCD_RELOAD_SYNC_EN defers reloads to the channel's terminal count.
package prog_clk_div_pkg;

  localparam int unsigned PCD_WIDTH    = 32;
  localparam logic [31:0] PCD_RST_HALF = 32'd20000000;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_PARK  = 2'd2
  } pcd_state_t;

endpackage

// File: rtl/pcd_chan.sv
// One divider channel: half-period counter, toggle flop, reload port.
// PCD_RELOAD_SYNC_EN holds a reload as pending until terminal count.
module pcd_chan
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned      WIDTH    = PCD_WIDTH,
  parameter logic [WIDTH-1:0] RST_HALF = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_half,
`ifdef PCD_RELOAD_SYNC_EN
  output logic             pend,
`endif
  output logic             div
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] half;
  logic             tc;

  assign tc = (cnt == half);

`ifdef PCD_RELOAD_SYNC_EN
  logic [WIDTH-1:0] pend_half;

  // New half applies only at terminal count, so the running half completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      half      <= RST_HALF;
      div       <= 1'b0;
      pend      <= 1'b0;
      pend_half <= '0;
    end else begin
      if (load) begin
        pend      <= 1'b1;
        pend_half <= load_half;
      end
      if (tc) begin
        cnt <= '0;
        div <= ~div;
        if (pend) begin
          half <= pend_half;
          pend <= 1'b0;
        end
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      half <= RST_HALF;
      div  <= 1'b0;
    end else if (load) begin
      half <= load_half;
      cnt  <= '0;
    end else if (tc) begin
      cnt <= '0;
      div <= ~div;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end
`endif

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable divider with glitch-free output select.
// PCD_RELOAD_SYNC_EN: reloads wait for the channel's terminal count.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int unsigned WIDTH    = PCD_WIDTH,
  parameter logic [31:0] RST_HALF = PCD_RST_HALF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [$clog2(NCH)-1:0] sel,
  input  logic                   load_valid,
  input  logic [$clog2(NCH)-1:0] load_ch,
  input  logic [WIDTH-1:0]       load_half,
  output logic                   load_ready,
  output logic [NCH-1:0]         div_o,
  output logic                   clk_o,
  output logic [$clog2(NCH)-1:0] active_sel,
  output logic                   busy,
  output logic                   err
);

  localparam int SW = $clog2(NCH);

  pcd_state_t    state;
  logic [SW-1:0] target;
  logic          sel_ok;
  logic          ld_ok;
  logic          acc;

  assign sel_ok = 32'(sel) < 32'(NCH);
  assign ld_ok  = 32'(load_ch) < 32'(NCH);
  assign acc    = load_valid && load_ready;

`ifdef PCD_RELOAD_SYNC_EN
  logic [NCH-1:0] pend;
  assign load_ready = ~|pend;
`else
  assign load_ready = 1'b1;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pcd_chan #(
      .WIDTH    (WIDTH),
      .RST_HALF (WIDTH'(RST_HALF))
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (acc && ld_ok && (32'(load_ch) == 32'(k))),
      .load_half (load_half),
`ifdef PCD_RELOAD_SYNC_EN
      .pend      (pend[k]),
`endif
      .div       (div_o[k])
    );
  end

  // Old channel must finish its high phase, new one must be low before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      active_sel <= '0;
      target     <= '0;
      busy       <= 1'b0;
      clk_o      <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= (acc && !ld_ok) || (state == S_RUN && !sel_ok);
      unique case (state)
        S_RUN: begin
          clk_o <= div_o[active_sel];
          if (sel_ok && sel != active_sel) begin
            target <= sel;
            busy   <= 1'b1;
            state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          clk_o <= div_o[active_sel];
          if (!div_o[active_sel]) state <= S_PARK;
        end
        S_PARK: begin
          clk_o <= 1'b0;
          if (!div_o[target]) begin
            active_sel <= target;
            busy       <= 1'b0;
            state      <= S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div (NCH=5, WIDTH=8, RST_HALF=6).
// Covers periods, switching, reload timing, errors and mid-switch reset.
module tb_prog_clk_div;
  import prog_clk_div_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sel;
  logic       load_valid;
  logic [2:0] load_ch;
  logic [7:0] load_half;
  logic       load_ready;
  logic [4:0] div_o;
  logic       clk_o;
  logic [2:0] active_sel;
  logic       busy;
  logic       err;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  prog_clk_div #(
    .NCH      (5),
    .WIDTH    (8),
    .RST_HALF (32'd6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_half  (load_half),
    .load_ready (load_ready),
    .div_o      (div_o),
    .clk_o      (clk_o),
    .active_sel (active_sel),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input logic [2:0] ch, input logic [7:0] h);
    int n;
    n = 0;
    while (!load_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ld_wait", 32'(n < 100), 1);
    load_valid = 1'b1;
    load_ch    = ch;
    load_half  = h;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic measure(input int k, input int h);
    int n;
    n = 0;
    while (div_o[k] && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!div_o[k] && n < 100) begin @(negedge clk); n++; end
    n = 1;
    @(negedge clk);
    while (div_o[k] && n < 100) begin n++; @(negedge clk); end
    check($sformatf("hi%0d", k), n, h + 1);
    n = 1;
    @(negedge clk);
    while (!div_o[k] && n < 100) begin n++; @(negedge clk); end
    check($sformatf("lo%0d", k), n, h + 1);
  endtask

  initial begin
    int n, hl, rr, t1, t2, t3;
    bit seen, done, short_p, park_bad;
    logic d;
    logic [7:0] hv [5];

    rst = 1'b1; sel = 3'd0; load_valid = 1'b0;
    load_ch = 3'd0; load_half = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_div", 32'(div_o), 0);
    check("rst_clk", 32'(clk_o), 0);
    check("rst_act", 32'(active_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdy", 32'(load_ready), 1);
    check("rst_half", 32'(dut.g_ch[2].u_ch.half), 6);

    load(3'd0, 8'd0);
    load(3'd1, 8'd1);
    load(3'd2, 8'd4);
    load(3'd3, 8'd9);
    load(3'd4, 8'd2);
    repeat (30) @(negedge clk);
    measure(0, 0);
    measure(1, 1);
    measure(2, 4);
    measure(3, 9);

    // switch 0 -> 3 with half0 = 4
    load(3'd0, 8'd4);
    repeat (12) @(negedge clk);
    n = 0;
    while (!clk_o && n < 100) begin @(negedge clk); n++; end
    while (clk_o && n < 100) begin @(negedge clk); n++; end
    sel = 3'd3;
    hl = 0; seen = 0; done = 0; short_p = 0; park_bad = 0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (clk_o) hl++;
      else begin
        if (hl > 0 && hl < 5) short_p = 1;
        hl = 0;
      end
      if (busy) seen = 1;
      if (dut.state == S_PARK && clk_o) park_bad = 1;
      if (seen && !busy && !done) begin
        done = 1;
        check("sw_act", 32'(active_sel), 3);
        n = 160;
      end
    end
    check("sw_busy", 32'(seen), 1);
    check("sw_done", 32'(done), 1);
    check("sw_short", 32'(short_p), 0);
    check("sw_park", 32'(park_bad), 0);

    // out-of-range select and load channel
    @(negedge clk);
    sel = 3'd5;
    @(negedge clk);
    check("err_sel", 32'(err), 1);
    sel = 3'd3;
    @(negedge clk);
    check("err_sel_off", 32'(err), 0);
    check("err_sel_act", 32'(active_sel), 3);
    check("err_sel_busy", 32'(busy), 0);
    load_valid = 1'b1; load_ch = 3'd7; load_half = 8'd1;
    @(negedge clk);
    load_valid = 1'b0;
    check("err_ld", 32'(err), 1);
    @(negedge clk);
    check("err_ld_off", 32'(err), 0);
    repeat (12) @(negedge clk);
    hv[0] = dut.g_ch[0].u_ch.half;
    hv[1] = dut.g_ch[1].u_ch.half;
    hv[2] = dut.g_ch[2].u_ch.half;
    hv[3] = dut.g_ch[3].u_ch.half;
    check("err_h0", 32'(hv[0]), 4);
    check("err_h1", 32'(hv[1]), 1);
    check("err_h2", 32'(hv[2]), 4);
    check("err_h3", 32'(hv[3]), 9);

    // reload ch1 from 4 to 2 mid half-period
    load(3'd1, 8'd4);
    n = 0;
    while (!load_ready && n < 100) begin @(negedge clk); n++; end
    repeat (12) @(negedge clk);
    n = 0;
    while (div_o[1] && n < 100) begin @(negedge clk); n++; end
    while (!div_o[1] && n < 100) begin @(negedge clk); n++; end
    rr = cyc;
    @(negedge clk);
    load_valid = 1'b1; load_ch = 3'd1; load_half = 8'd2;
    @(negedge clk);
    load_valid = 1'b0;
`ifdef PCD_RELOAD_SYNC_EN
    check("rl_rdy_lo", 32'(load_ready), 0);
`else
    check("rl_cnt0", 32'(dut.g_ch[1].u_ch.cnt), 0);
    check("rl_rdy", 32'(load_ready), 1);
`endif
    d = div_o[1];
    t1 = 0; t2 = 0; t3 = 0;
    n = 0;
    while (t3 == 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (div_o[1] != d) begin
        d = div_o[1];
        if (t1 == 0) begin
          t1 = cyc;
`ifdef PCD_RELOAD_SYNC_EN
          check("rl_rdy_hi", 32'(load_ready), 1);
`endif
        end else if (t2 == 0) t2 = cyc;
        else t3 = cyc;
      end
    end
    check("rl_first", t1 - rr, 5);
    check("rl_second", t2 - t1, 3);
    check("rl_third", t3 - t2, 3);

    // reset while draining channel 3
    n = 0;
    while (!div_o[3] && n < 100) begin @(negedge clk); n++; end
    sel = 3'd0;
    @(negedge clk);
    check("rs_drain", 32'(dut.state), 32'(S_DRAIN));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs_clk", 32'(clk_o), 0);
    check("rs_busy", 32'(busy), 0);
    check("rs_act", 32'(active_sel), 0);
    check("rs_err", 32'(err), 0);
    check("rs_h0", 32'(dut.g_ch[0].u_ch.half), 6);
    check("rs_h1", 32'(dut.g_ch[1].u_ch.half), 6);
    check("rs_h2", 32'(dut.g_ch[2].u_ch.half), 6);
    check("rs_h3", 32'(dut.g_ch[3].u_ch.half), 6);
    check("rs_h4", 32'(dut.g_ch[4].u_ch.half), 6);
    repeat (3) @(negedge clk);
    check("rs_clk_after", 32'(clk_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
